// File: rtl/io_pkg.sv
// Shared constants and types for the IO-class instruction stage (opcode 1100: in/out).
package io_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [3:0] OP_IO    = 4'b1100;
    localparam logic [2:0] FUNK_IN  = 3'b000;
    localparam logic [2:0] FUNK_OUT = 3'b001;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_HELD  = 1'b1
    } in_state_t;

endpackage

// File: rtl/io_out_fifo.sv
// Show-ahead circular output FIFO; a full FIFO accepts a push when it is popped in the same cycle.
module io_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic empty;
    logic push;
    logic pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign rd_valid = !empty;
    assign pop      = rd_valid & rd_ready;
    assign push     = wr_en & (!full | pop);
    assign drop     = wr_en & full & !pop;

    // No bypass: a freshly pushed word becomes visible only after the edge.
    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately left out of reset; stale words are masked by the empty check.
    always_ff @(posedge clk) begin
        if (!srst && push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// IO stage behind the control unit: output FIFO toward the device, one-word input buffer toward writeback.
// Build option: define IO_IN_BYPASS_EN to forward ext_in_data straight to InData on an InRead with the buffer empty.
module io_port_unit
    import io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              OutputWrite,
    input  logic [DATA_W-1:0] OutData,
    input  logic              InRead,
    output logic [DATA_W-1:0] InData,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic              out_full,
    output logic              in_empty,
    output logic              overflow,
    output logic              underflow
);

    logic out_drop;

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (CLK),
        .srst     (Reset),
        .wr_en    (OutputWrite),
        .wr_data  (OutData),
        .rd_ready (ext_out_ready),
        .rd_data  (ext_out_data),
        .rd_valid (ext_out_valid),
        .full     (out_full),
        .drop     (out_drop)
    );

    in_state_t         state_reg, state_next;
    logic [DATA_W-1:0] in_buf_reg, in_buf_next;
    logic              overflow_reg, underflow_reg;
    logic              underflow_set;
    logic              bypass;

`ifdef IO_IN_BYPASS_EN
    assign bypass = (state_reg == IN_EMPTY) & InRead & ext_in_valid;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        in_buf_next   = in_buf_reg;
        InData        = '0;
        ext_in_ready  = 1'b0;
        underflow_set = 1'b0;
        case (state_reg)
            IN_EMPTY: begin
                ext_in_ready = 1'b1;
                if (bypass) begin
                    // Word is handed straight to writeback and never lands in the buffer.
                    InData = ext_in_data;
                end else begin
                    underflow_set = InRead;
                    if (ext_in_valid) begin
                        in_buf_next = ext_in_data;
                        state_next  = IN_HELD;
                    end
                end
            end
            IN_HELD: begin
                InData = in_buf_reg;
                if (InRead) begin
                    state_next = IN_EMPTY;
                end
            end
            default: begin
                state_next = IN_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg     <= IN_EMPTY;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            overflow_reg  <= overflow_reg | out_drop;
            underflow_reg <= underflow_reg | underflow_set;
        end
    end

    always_ff @(posedge CLK) begin
        in_buf_reg <= in_buf_next;
    end

    assign in_empty  = (state_reg == IN_EMPTY);
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: expected words are queued at stimulus time, monitors compare on handshake.
module tb_io_port_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        OutputWrite;
    logic [15:0] OutData;
    logic        InRead;
    logic [15:0] InData;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [15:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
    logic        out_full;
    logic        in_empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] out_q[$];
    logic [15:0] in_q[$];

    io_port_unit #(.DATA_W(16), .OUT_DEPTH(4)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .OutputWrite   (OutputWrite),
        .OutData       (OutData),
        .InRead        (InRead),
        .InData        (InData),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .out_full      (out_full),
        .in_empty      (in_empty),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        OutputWrite   = 1'b0;
        OutData       = '0;
        InRead        = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
    endtask

    // Output monitor: every accepted head word must match the next queued word.
    always @(negedge CLK) begin
        if (!Reset && ext_out_valid && ext_out_ready) begin
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %h expected none", ext_out_data);
            end else begin
                check("out_data", {16'h0, ext_out_data}, {16'h0, out_q.pop_front()});
            end
        end
    end

    // Input monitor: InData during an InRead cycle is what writeback latches.
    always @(negedge CLK) begin
        if (!Reset && InRead) begin
            if (in_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL in_unexpected: got %h expected none", InData);
            end else begin
                check("in_data", {16'h0, InData}, {16'h0, in_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        @(negedge CLK);
        check("rst_out_valid", ext_out_valid, 0);
        check("rst_in_ready", ext_in_ready, 1);
        check("rst_in_empty", in_empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_indata", InData, 0);
        check("rst_out_data", ext_out_data, 0);
        check("rst_out_full", out_full, 0);

        // Three pushes with the device stalled, then drain in order.
        for (int i = 1; i <= 3; i++) begin
            OutData = 16'(i);
            OutputWrite = 1'b1;
            out_q.push_back(16'(i));
            step();
        end
        OutputWrite = 1'b0;
        @(negedge CLK);
        check("stall_valid", ext_out_valid, 1);
        check("stall_head", ext_out_data, 16'h0001);
        check("stall_not_full", out_full, 0);
        step();
        ext_out_ready = 1'b1;
        repeat (3) step();
        @(negedge CLK);
        check("drain3_valid", ext_out_valid, 0);
        check("drain3_q_empty", out_q.size(), 0);
        step();
        ext_out_ready = 1'b0;

        // Five pushes into a 4-deep FIFO: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            OutData = 16'hA000 + 16'(i);
            OutputWrite = 1'b1;
            if (i < 4) out_q.push_back(16'hA000 + 16'(i));
            step();
            if (i == 3) begin
                @(negedge CLK);
                check("full_after4", out_full, 1);
                check("no_ovf_after4", overflow, 0);
            end
        end
        OutputWrite = 1'b0;
        @(negedge CLK);
        check("ovf_after5", overflow, 1);
        step();
        ext_out_ready = 1'b1;
        repeat (4) step();
        @(negedge CLK);
        check("drainA_valid", ext_out_valid, 0);
        check("drainA_q_empty", out_q.size(), 0);
        step();

        // Full FIFO pushed and popped together, then wrap the pointers.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            OutData = 16'hC000 + 16'(i);
            OutputWrite = 1'b1;
            out_q.push_back(16'hC000 + 16'(i));
            step();
        end
        OutData = 16'hBEEF;
        OutputWrite = 1'b1;
        ext_out_ready = 1'b1;
        out_q.push_back(16'hBEEF);
        step();
        OutputWrite = 1'b0;
        ext_out_ready = 1'b0;
        @(negedge CLK);
        check("pushpop_full", out_full, 1);
        check("pushpop_no_ovf", overflow, 0);
        step();
        ext_out_ready = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            OutData = 16'hE000 + 16'(i);
            OutputWrite = 1'b1;
            out_q.push_back(16'hE000 + 16'(i));
            step();
        end
        OutputWrite = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        check("wrap_valid", ext_out_valid, 0);
        check("wrap_no_ovf", overflow, 0);
        check("wrap_q_empty", out_q.size(), 0);
        step();
        ext_out_ready = 1'b0;

        // Input capture, ignore while held, then consume.
        ext_in_data = 16'h1234;
        ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        @(negedge CLK);
        check("held_in_empty", in_empty, 0);
        check("held_in_ready", ext_in_ready, 0);
        check("held_indata", InData, 16'h1234);
        step();
        ext_in_data = 16'h5678;
        ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        @(negedge CLK);
        check("held_ignore", InData, 16'h1234);
        step();
        InRead = 1'b1;
        in_q.push_back(16'h1234);
        step();
        InRead = 1'b0;
        @(negedge CLK);
        check("read_in_empty", in_empty, 1);
        check("read_indata", InData, 0);
        check("read_no_underflow", underflow, 0);
        step();

        // InRead against an empty buffer while the device offers a word.
        ext_in_data = 16'h00FF;
        ext_in_valid = 1'b1;
        InRead = 1'b1;
`ifdef IO_IN_BYPASS_EN
        in_q.push_back(16'h00FF);
`else
        in_q.push_back(16'h0000);
`endif
        @(negedge CLK);
        check("uf_same_in_ready", ext_in_ready, 1);
        step();
        InRead = 1'b0;
        ext_in_valid = 1'b0;
        @(negedge CLK);
`ifdef IO_IN_BYPASS_EN
        check("byp_underflow", underflow, 0);
        check("byp_in_empty", in_empty, 1);
        check("byp_indata_after", InData, 0);
`else
        check("uf_underflow", underflow, 1);
        check("uf_in_empty", in_empty, 0);
        check("uf_indata_after", InData, 16'h00FF);
`endif
        check("in_q_empty", in_q.size(), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- I/O stage directly downstream of the multicycle control unit.
- Executes the IO-class instructions (opcode 4'b1100): funk 3'b001 is "out" and funk 3'b000 is "in".
- "out": the control unit's OutputWrite pushes a register value into an output FIFO, which drains to the external device over a valid/ready handshake.
- "in": an external word is held in a one-entry buffer, and the datapath reads it during writeback through the MemtoReg mux.

Parameters:
- DATA_W, 16, datapath word width.
- OUT_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- OutputWrite  in  1  from control unit; push OutData this cycle.
- OutData  in  DATA_W  register-file read value (rs of the out instruction).
- InRead  in  1  from datapath; the writeback cycle of an "in" instruction consumes the input word.
- InData  out  DATA_W  word presented to the MemtoReg mux.
- ext_out_data  out  DATA_W  FIFO head.
- ext_out_valid  out  1  FIFO non-empty.
- ext_out_ready  in  1  device accepts head.
- ext_in_data  in  DATA_W  device word.
- ext_in_valid  in  1  device offers word.
- ext_in_ready  out  1  input buffer empty.
- out_full  out  1  FIFO count == OUT_DEPTH.
- in_empty  out  1  input buffer empty.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: InRead occurred with the buffer empty.

Behaviour:
- Reset, synchronous: FIFO pointers and count = 0, in_full = 0, overflow = underflow = 0.
  - Resulting outputs: ext_out_valid = 0, out_full = 0, ext_in_ready = 1, in_empty = 1, InData = 0, ext_out_data = 0.
  - Reset wins over every simultaneous event; FIFO storage contents are not cleared.
- Output FIFO:
  - Circular buffer with rd/wr pointers of log2(OUT_DEPTH) bits and a count of log2(OUT_DEPTH)+1 bits. Show-ahead: ext_out_data = mem[rd_ptr], or 0 when empty.
  - pop = ext_out_valid & ext_out_ready.
  - push = OutputWrite & (count < OUT_DEPTH | pop). A full FIFO with a simultaneous pop accepts the push.
  - OutputWrite while full and not popping: the data is dropped and overflow is set (sticky).
  - Latency: a push into an empty FIFO at edge N gives ext_out_valid = 1 in the cycle after edge N; there is no bypass.
  - Pointers wrap modulo OUT_DEPTH.
  - Count update: push & pop leaves count unchanged; push alone increments it; pop alone decrements it.
  - ext_out_data is stable while valid & !ready.
- Input buffer, 2-state FSM:
  - EMPTY: ext_in_ready = 1, in_empty = 1, InData = 0.
    - ext_in_valid captures ext_in_data and moves to HELD.
    - InRead in EMPTY sets underflow (sticky). Capture still occurs in the same cycle.
  - HELD: ext_in_ready = 0, InData = in_buf (combinational).
    - InRead moves to EMPTY at the edge. A new capture is possible from the next cycle.
    - ext_in_valid is ignored while in HELD.
- The input and output sides are independent; OutputWrite and InRead in the same cycle are both honoured.
- The control unit never stalls. Software polls out_full and in_empty, which are mapped by the datapath, before issuing out or in.

Optional Feature:
- Macro: IO_IN_BYPASS_EN.
- Defined: in EMPTY with InRead & ext_in_valid in the same cycle:
  - InData = ext_in_data and the word is consumed (not captured);
  - underflow is not set and the FSM stays in EMPTY;
  - ext_in_ready = 1 in that cycle.
- Undefined: the base behaviour applies (underflow set, word captured, InData = 0).

Decomposition:
- Package io_pkg holds:
  - DATA_W_DEFAULT = 16;
  - OP_IO = 4'b1100, FUNK_IN = 3'b000, FUNK_OUT = 3'b001;
  - an input FSM state typedef {IN_EMPTY, IN_HELD}.
- Sub-module io_out_fifo (parameters DATA_W, DEPTH) contains the circular buffer and push/pop/count logic. The top level holds the input FSM, the sticky flags and the bypass logic.

Test Plan:
- Reset asserted 2 cycles, then released -> ext_out_valid = 0, ext_in_ready = 1, in_empty = 1, overflow = underflow = 0, InData = 0.
- OutputWrite pulses with 16'h0001, 16'h0002, 16'h0003, ext_out_ready = 0 -> count 3, head 16'h0001. Raise ready -> 0001, 0002, 0003 drain in order on consecutive cycles, then ext_out_valid = 0.
- 5 pushes (16'hA000..16'hA004) with ready = 0 -> out_full = 1 after the 4th push, overflow = 1 after the 5th, drain yields A000..A003 only.
- FIFO full, ready = 1 and OutputWrite 16'hBEEF in the same cycle -> overflow stays 0, count stays 4, BEEF drained last. Wrap exercised over 10 pushes.
- ext_in_valid with 16'h1234 -> next cycle HELD, InData = 16'h1234, ext_in_ready = 0. Offer 16'h5678 while HELD -> ignored. InRead -> EMPTY, InData = 0.
- InRead with the buffer empty and ext_in_valid = 1 (16'h00FF):
  - base -> underflow = 1, next cycle InData = 16'h00FF;
  - with IO_IN_BYPASS_EN -> InData = 16'h00FF that same cycle, underflow = 0, next cycle in_empty = 1.
